sseg_mux_decoder: RTL and testbench

Receiver for the multiplexed 4-digit seven-segment display bus that `led_switch` drives. The block samples the active-low segment lines and one-hot digit selects from FMC inputs and rebuilds the per-digit segment patterns. It decodes each pattern to a hex nibble and reports frame completion, multi-select errors and staleness. It is used for on-board loopback self-test of display drivers and as a bench monitor.

---
 rtl/sseg_mux_decoder.sv | 146 ++++++++++++++
 tb/tb_sseg_mux_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_mux_decoder.sv
// Receiver for a multiplexed 4-digit seven-segment bus: synchronizes the pins,
// captures each settled digit, decodes it to hex and reports frame/error/stale status.
module sseg_mux_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_sseg_n,
  input  logic [3:0]  i_ldsel,
  output logic [31:0] o_seg,
  output logic [15:0] o_hex,
  output logic [3:0]  o_hex_valid,
  output logic        o_frame,
  output logic        o_mh_err,
  output logic        o_stale
);

  localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_WAIT, ST_CAPTURE, ST_HOLD} state_t;

  logic [11:0] sync1, sync2;
  logic [7:0]  s_sseg, p_sseg;
  logic [3:0]  s_ldsel, p_ldsel;
  logic [7:0]  stab_cnt;
  logic [19:0] to_cnt;
  logic [3:0]  seen, seen_next;
  logic [1:0]  sel_idx;
  logic [7:0]  cap_seg;
  logic [4:0]  dec;
  logic        change, one_hot, multi_hot, capture, frame_now;
  state_t      state, state_next;

  // Returns {valid, nibble} for an active-high gfedcba pattern.
  function automatic logic [4:0] decode(input logic [6:0] g);
    case (g)
      7'h3F: decode = 5'h10;  7'h06: decode = 5'h11;
      7'h5B: decode = 5'h12;  7'h4F: decode = 5'h13;
      7'h66: decode = 5'h14;  7'h6D: decode = 5'h15;
      7'h7D: decode = 5'h16;  7'h07: decode = 5'h17;
      7'h7F: decode = 5'h18;  7'h6F: decode = 5'h19;
      7'h77: decode = 5'h1A;  7'h7C: decode = 5'h1B;
      7'h39: decode = 5'h1C;  7'h5E: decode = 5'h1D;
      7'h79: decode = 5'h1E;  7'h71: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  // NOTE: asynchronous reset must appear in the sensitivity list; state uses <= only.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1    <= '0;
      sync2    <= '0;
      p_sseg   <= '0;
      p_ldsel  <= '0;
      stab_cnt <= '0;
    end else begin
      sync1   <= {i_sseg_n, i_ldsel};
      sync2   <= sync1;
      p_sseg  <= s_sseg;
      p_ldsel <= s_ldsel;
      if (change)                stab_cnt <= '0;
      else if (stab_cnt != 8'hFF) stab_cnt <= stab_cnt + 8'd1;
    end
  end

  assign s_sseg    = sync2[11:4];
  assign s_ldsel   = sync2[3:0];
  assign change    = {s_sseg, s_ldsel} != {p_sseg, p_ldsel};
  assign multi_hot = (s_ldsel & (s_ldsel - 4'd1)) != 4'd0;
  assign one_hot   = (s_ldsel != 4'd0) && !multi_hot;
  assign cap_seg   = ~s_sseg;
  assign dec       = decode(cap_seg[6:0]);

  always_comb begin
    sel_idx = 2'd0;
    case (s_ldsel)
      4'b0010: sel_idx = 2'd1;
      4'b0100: sel_idx = 2'd2;
      4'b1000: sel_idx = 2'd3;
      default: sel_idx = 2'd0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= ST_WAIT;
    else         state <= state_next;
  end

  // Capture fires on the WAIT->CAPTURE edge so outputs update SETTLE_CYCLES+3 edges after a pin change.
  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned (no latches).
    state_next = state;
    capture    = 1'b0;
    case (state)
      ST_WAIT: begin
        if (!change && one_hot && stab_cnt == SETTLE_LAST) begin
          state_next = ST_CAPTURE;
          capture    = 1'b1;
        end
      end
      ST_CAPTURE: state_next = change ? ST_WAIT : ST_HOLD;
      ST_HOLD:    if (change) state_next = ST_WAIT;
      default:    state_next = ST_WAIT;
    endcase
  end

  assign seen_next = seen | (4'b0001 << sel_idx);
  assign frame_now = capture && (seen_next == 4'hF);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_seg       <= '0;
      o_hex       <= '0;
      o_hex_valid <= '0;
      o_frame     <= 1'b0;
      o_mh_err    <= 1'b0;
      o_stale     <= 1'b0;
      seen        <= '0;
      to_cnt      <= '0;
    end else begin
      o_frame  <= frame_now;
      o_mh_err <= o_mh_err | multi_hot;
      if (capture) begin
        o_seg[8*sel_idx +: 8]  <= cap_seg;
        o_hex[4*sel_idx +: 4]  <= dec[3:0];
        o_hex_valid[sel_idx]   <= dec[4];
        seen                   <= frame_now ? 4'h0 : seen_next;
      end
      // A frame completing in the timeout cycle wins over the timeout.
      if (frame_now) begin
        to_cnt  <= '0;
        o_stale <= 1'b0;
      end else begin
        if (to_cnt != 20'hFFFFF) to_cnt <= to_cnt + 20'd1;
        if (to_cnt == TIMEOUT_LAST) begin
          o_stale     <= 1'b1;
          o_hex_valid <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sseg_mux_decoder.sv
// Directed self-checking bench for sseg_mux_decoder (SETTLE_CYCLES=16, TIMEOUT_CYCLES=256).
module tb_sseg_mux_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  sseg_n = 8'hFF;
  logic [3:0]  ldsel = 4'h0;
  logic [31:0] seg;
  logic [15:0] hex;
  logic [3:0]  hex_valid;
  logic        frame, mh_err, stale;

  int errors = 0;
  int checks = 0;

  sseg_mux_decoder #(.SETTLE_CYCLES(16), .TIMEOUT_CYCLES(256)) dut (
    .i_clk(clk), .i_reset(rst), .i_sseg_n(sseg_n), .i_ldsel(ldsel),
    .o_seg(seg), .o_hex(hex), .o_hex_valid(hex_valid),
    .o_frame(frame), .o_mh_err(mh_err), .o_stale(stale)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit before driving or sampling.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] sel, input logic [7:0] pat);
    ldsel  = sel;
    sseg_n = ~pat;
  endtask

  task automatic apply_reset();
    drive(4'h0, 8'h00);
    rst = 1'b1;
    wait_edges(2);
    rst = 1'b0;
    wait_edges(3);
  endtask

  // Hold one digit for n edges, reporting o_frame pulses seen during the dwell.
  task automatic dwell(input logic [3:0] sel, input logic [7:0] pat, input int n,
                       output int frames, output int frame_edge);
    drive(sel, pat);
    frames = 0;
    frame_edge = -1;
    for (int e = 1; e <= n; e++) begin
      wait_edges(1);
      if (frame) begin
        frames++;
        frame_edge = e;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (seg !== 32'h0)       begin errors++; $display("FAIL reset_seg: got %h want 0", seg); end
    checks++; if (hex !== 16'h0)       begin errors++; $display("FAIL reset_hex: got %h want 0", hex); end
    checks++; if (hex_valid !== 4'h0)  begin errors++; $display("FAIL reset_valid: got %h want 0", hex_valid); end
    checks++; if ({frame, mh_err, stale} !== 3'b000)
      begin errors++; $display("FAIL reset_flags: got %b want 000", {frame, mh_err, stale}); end
  endtask

  task automatic test_single_digit();
    int frames;
    apply_reset();
    drive(4'b0001, 8'h3F);
    frames = 0;
    for (int e = 1; e <= 40; e++) begin
      wait_edges(1);
      if (frame) frames++;
      if (e == 18) begin
        checks++; if (seg[7:0] !== 8'h00) begin errors++; $display("FAIL single_early: got %h want 00", seg[7:0]); end
      end
      if (e == 19) begin
        checks++; if (seg[7:0] !== 8'h3F) begin errors++; $display("FAIL single_seg: got %h want 3f", seg[7:0]); end
        checks++; if (hex[3:0] !== 4'h0)  begin errors++; $display("FAIL single_hex: got %h want 0", hex[3:0]); end
        checks++; if (hex_valid !== 4'b0001) begin errors++; $display("FAIL single_valid: got %b want 0001", hex_valid); end
      end
    end
    checks++; if (frames !== 0) begin errors++; $display("FAIL single_noframe: got %0d pulses want 0", frames); end
  endtask

  task automatic test_full_frame();
    logic [7:0] pats [4] = '{8'h06, 8'h5B, 8'h4F, 8'h66};
    int frames, fe, total, last_fe;
    apply_reset();
    total = 0;
    last_fe = -1;
    for (int d = 0; d < 4; d++) begin
      dwell(4'(1 << d), pats[d], 20, frames, fe);
      total += frames;
      if (d == 3) last_fe = fe;
    end
    checks++; if (total !== 1)   begin errors++; $display("FAIL frame_count: got %0d want 1", total); end
    checks++; if (last_fe !== 19) begin errors++; $display("FAIL frame_edge: got %0d want 19", last_fe); end
    checks++; if (hex !== 16'h4321) begin errors++; $display("FAIL frame_hex: got %h want 4321", hex); end
    checks++; if (hex_valid !== 4'hF) begin errors++; $display("FAIL frame_valid: got %h want f", hex_valid); end
    checks++; if (seg !== 32'h664F5B06) begin errors++; $display("FAIL frame_seg: got %h want 664f5b06", seg); end
  endtask

  task automatic test_short_dwell_glitch();
    int frames, fe;
    apply_reset();
    dwell(4'b0100, 8'h6D, 10, frames, fe);
    dwell(4'b0000, 8'h00, 10, frames, fe);
    checks++; if (seg[23:16] !== 8'h00) begin errors++; $display("FAIL short_seg: got %h want 00", seg[23:16]); end
    checks++; if (hex_valid[2] !== 1'b0) begin errors++; $display("FAIL short_valid: got %b want 0", hex_valid[2]); end
    dwell(4'b0100, 8'h7D, 10, frames, fe);
    drive(4'b0100, 8'h7C);
    wait_edges(1);
    drive(4'b0100, 8'h7D);
    for (int e = 1; e <= 22; e++) begin
      wait_edges(1);
      if (e == 18) begin
        checks++; if (seg[23:16] !== 8'h00) begin errors++; $display("FAIL glitch_early: got %h want 00", seg[23:16]); end
      end
      if (e == 19) begin
        checks++; if (seg[23:16] !== 8'h7D) begin errors++; $display("FAIL glitch_seg: got %h want 7d", seg[23:16]); end
        checks++; if (hex[11:8] !== 4'h6) begin errors++; $display("FAIL glitch_hex: got %h want 6", hex[11:8]); end
      end
    end
  endtask

  task automatic test_illegal();
    int frames, fe;
    apply_reset();
    dwell(4'b0001, 8'h7F, 20, frames, fe);
    dwell(4'b0010, 8'h06, 20, frames, fe);
    checks++; if (hex_valid !== 4'b0011) begin errors++; $display("FAIL illegal_pre_valid: got %b want 0011", hex_valid); end
    drive(4'b0110, 8'h3F);
    wait_edges(2);
    checks++; if (mh_err !== 1'b0) begin errors++; $display("FAIL mh_early: got %b want 0", mh_err); end
    wait_edges(1);
    checks++; if (mh_err !== 1'b1) begin errors++; $display("FAIL mh_set: got %b want 1", mh_err); end
    wait_edges(30);
    checks++; if (seg !== 32'h0000067F) begin errors++; $display("FAIL mh_nocapture: got %h want 0000067f", seg); end
    dwell(4'b0001, 8'h49, 100, frames, fe);
    checks++; if (mh_err !== 1'b1) begin errors++; $display("FAIL mh_sticky: got %b want 1", mh_err); end
    checks++; if (seg[7:0] !== 8'h49) begin errors++; $display("FAIL bad_glyph_seg: got %h want 49", seg[7:0]); end
    checks++; if (hex[3:0] !== 4'h0) begin errors++; $display("FAIL bad_glyph_hex: got %h want 0", hex[3:0]); end
    checks++; if (hex_valid !== 4'b0010) begin errors++; $display("FAIL bad_glyph_valid: got %b want 0010", hex_valid); end
  endtask

  task automatic test_stale();
    logic [7:0] pats_a [4] = '{8'h3F, 8'h06, 8'h5B, 8'h4F};
    logic [7:0] pats_b [4] = '{8'h66, 8'h6D, 8'h7D, 8'h07};
    int frames, fe, stale_edge, frame_seen;
    apply_reset();
    for (int d = 0; d < 3; d++) dwell(4'(1 << d), pats_a[d], 20, frames, fe);
    dwell(4'b1000, pats_a[3], 19, frames, fe);
    checks++; if (frames !== 1) begin errors++; $display("FAIL stale_pre_frame: got %0d want 1", frames); end
    drive(4'h0, 8'h00);
    stale_edge = -1;
    for (int k = 1; k <= 400 && stale_edge < 0; k++) begin
      wait_edges(1);
      if (stale) stale_edge = k;
    end
    checks++; if (stale_edge !== 256) begin errors++; $display("FAIL stale_edge: got %0d want 256", stale_edge); end
    checks++; if (hex_valid !== 4'h0) begin errors++; $display("FAIL stale_valid: got %h want 0", hex_valid); end
    checks++; if (seg !== 32'h4F5B063F) begin errors++; $display("FAIL stale_seg: got %h want 4f5b063f", seg); end
    checks++; if (hex !== 16'h3210) begin errors++; $display("FAIL stale_hex: got %h want 3210", hex); end
    for (int d = 0; d < 3; d++) dwell(4'(1 << d), pats_b[d], 20, frames, fe);
    drive(4'b1000, pats_b[3]);
    frame_seen = 0;
    for (int e = 1; e <= 20; e++) begin
      wait_edges(1);
      if (e == 18) begin
        checks++; if (stale !== 1'b1) begin errors++; $display("FAIL stale_held: got %b want 1", stale); end
      end
      if (frame) begin
        frame_seen++;
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL stale_clear: got %b want 0", stale); end
        checks++; if (hex !== 16'h7654) begin errors++; $display("FAIL stale_new_hex: got %h want 7654", hex); end
      end
    end
    checks++; if (frame_seen !== 1) begin errors++; $display("FAIL stale_new_frame: got %0d want 1", frame_seen); end
  endtask

  task automatic test_reset_mid_dwell();
    int frames, fe;
    apply_reset();
    dwell(4'b1000, 8'h07, 20, frames, fe);
    dwell(4'b0010, 8'h06, 20, frames, fe);
    checks++; if (seg === 32'h0) begin errors++; $display("FAIL mid_pre: got %h want nonzero", seg); end
    drive(4'b0001, 8'h6F);
    wait_edges(5);
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({seg, hex, hex_valid, frame, mh_err, stale} !== 55'h0)
      begin errors++; $display("FAIL mid_async: seg=%h hex=%h valid=%h flags=%b want all 0", seg, hex, hex_valid, {frame, mh_err, stale}); end
    wait_edges(1);
    rst = 1'b0;
    for (int e = 1; e <= 22; e++) begin
      wait_edges(1);
      if (e == 18) begin
        checks++; if (seg[7:0] !== 8'h00) begin errors++; $display("FAIL mid_early: got %h want 00", seg[7:0]); end
      end
      if (e == 19) begin
        checks++; if (seg[7:0] !== 8'h6F) begin errors++; $display("FAIL mid_seg: got %h want 6f", seg[7:0]); end
        checks++; if (hex[3:0] !== 4'h9) begin errors++; $display("FAIL mid_hex: got %h want 9", hex[3:0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_full_frame();
    test_short_dwell_glitch();
    test_illegal();
    test_stale();
    test_reset_mid_dwell();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
